// File: rtl/rv32i_csr_irq.sv
// Machine-mode CSR file for an RV32 core: counters, interrupt pending/enable
// arbitration, trap entry/MRET state and trap-target generation.
// Optional feature macro: CSR_VECTORED_EN (vectored mtvec mode).
module rv32i_csr_irq #(
    parameter int          CNT_WIDTH = 64,
    parameter int          NUM_IRQ   = 4,
    parameter logic [31:0] ADDR_MASK = 32'h00FF_FFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [11:0]        csr_addr,
    input  logic [2:0]         csr_op,
    input  logic [31:0]        csr_wdata,
    input  logic               csr_we,
    output logic [31:0]        csr_rdata,
    output logic               csr_illegal,
    input  logic               retire,
    input  logic               trap_valid,
    input  logic [31:0]        trap_cause,
    input  logic [31:0]        trap_pc,
    input  logic [31:0]        trap_value,
    input  logic               mret,
    input  logic [63:0]        mtime,
    input  logic               timer_irq,
    input  logic               sw_irq,
    input  logic               ext_irq,
    input  logic [NUM_IRQ-1:0] plat_irq,
    output logic               irq_req,
    output logic [31:0]        irq_cause,
    output logic [31:0]        trap_target,
    output logic [31:0]        mepc_out
);

    localparam logic [31:0] IRQ_MASK = ((32'd1 << NUM_IRQ) - 32'd1) << 16;
    localparam logic [31:0] MIE_MASK = 32'h0000_0888 | IRQ_MASK;

    // Zimm ops zero-extend the 5-bit immediate; set/clear merge with the old value.
    function automatic logic [31:0] csr_alu(input logic [2:0]  op,
                                            input logic [31:0] old,
                                            input logic [31:0] wdata);
        logic [31:0] src;
        src = op[2] ? {27'd0, wdata[4:0]} : wdata;
        case (op[1:0])
            2'b01:   csr_alu = src;
            2'b10:   csr_alu = old | src;
            2'b11:   csr_alu = old & ~src;
            default: csr_alu = old;
        endcase
    endfunction

    logic                 mstatus_mie_r;
    logic                 mstatus_mpie_r;
    logic [31:0]          mie_r;
    logic [31:0]          mtvec_r;
    logic [31:0]          mcountinhibit_r;
    logic [31:0]          mscratch_r;
    logic [31:0]          mepc_r;
    logic [31:0]          mcause_r;
    logic [31:0]          mtval_r;
    logic [CNT_WIDTH-1:0] mcycle_r;
    logic [CNT_WIDTH-1:0] minstret_r;
    logic                 timer_r;
    logic                 sw_r;
    logic                 ext_r;
    logic [NUM_IRQ-1:0]   plat_meta_r;
    logic [NUM_IRQ-1:0]   plat_sync_r;

    logic [31:0] mstatus_s;
    logic [31:0] mtvec_rd_s;
    logic [31:0] mip_s;
    logic [31:0] pending_s;
    logic [4:0]  code_s;
    logic [63:0] cyc64_s;
    logic [63:0] ret64_s;
    logic [63:0] cyc_nxt_s;
    logic [63:0] ret_nxt_s;
    logic [31:0] rdata_s;
    logic        bad_addr_s;
    logic        illegal_s;
    logic        wen_s;
    logic [31:0] wval_s;
    logic [31:0] tvec_base_s;
    logic [31:0] target_s;

    assign mstatus_s = {19'd0, 2'b11, 3'd0, mstatus_mpie_r, 3'd0, mstatus_mie_r, 3'd0};
    assign cyc64_s   = 64'(mcycle_r);
    assign ret64_s   = 64'(minstret_r);
    assign mip_s     = (32'(plat_sync_r) << 16)
                     | {20'd0, ext_r, 3'd0, timer_r, 3'd0, sw_r, 3'd0};
    assign pending_s = mip_s & mie_r;

`ifdef CSR_VECTORED_EN
    assign mtvec_rd_s = {mtvec_r[31:2], 1'b0, mtvec_r[0]};
`else
    assign mtvec_rd_s = {mtvec_r[31:2], 2'b00};
`endif

    // Read mux and address legality decode.
    always_comb begin
        rdata_s    = 32'd0;
        bad_addr_s = 1'b0;
        case (csr_addr)
            12'h300:            rdata_s = mstatus_s;
            12'h301:            rdata_s = 32'h4000_0100;
            12'h304:            rdata_s = mie_r;
            12'h305:            rdata_s = mtvec_rd_s;
            12'h320:            rdata_s = mcountinhibit_r;
            12'h340:            rdata_s = mscratch_r;
            12'h341:            rdata_s = mepc_r;
            12'h342:            rdata_s = mcause_r;
            12'h343:            rdata_s = mtval_r;
            12'h344:            rdata_s = mip_s;
            12'hB00, 12'hC00:   rdata_s = cyc64_s[31:0];
            12'hB80, 12'hC80:   rdata_s = cyc64_s[63:32];
            12'hB02, 12'hC02:   rdata_s = ret64_s[31:0];
            12'hB82, 12'hC82:   rdata_s = ret64_s[63:32];
            12'hC01:            rdata_s = mtime[31:0];
            12'hC81:            rdata_s = mtime[63:32];
            12'hF11, 12'hF12,
            12'hF13, 12'hF14:   rdata_s = 32'd0;
            default:            bad_addr_s = 1'b1;
        endcase
    end

    assign illegal_s   = bad_addr_s | (csr_we & (csr_addr[11:10] == 2'b11));
    assign wen_s       = csr_we & ~illegal_s;
    assign wval_s      = csr_alu(csr_op, rdata_s, csr_wdata);
    assign csr_rdata   = rdata_s;
    assign csr_illegal = illegal_s;

    // Counter next values: a write replaces one half and drops that cycle's increment.
    always_comb begin
        cyc_nxt_s = cyc64_s;
        ret_nxt_s = ret64_s;
        if (wen_s && (csr_addr == 12'hB00)) begin
            cyc_nxt_s = {cyc64_s[63:32], wval_s};
        end else if (wen_s && (csr_addr == 12'hB80)) begin
            cyc_nxt_s = {wval_s, cyc64_s[31:0]};
        end else if (!mcountinhibit_r[0]) begin
            cyc_nxt_s = cyc64_s + 64'd1;
        end else begin
            cyc_nxt_s = cyc64_s;
        end
        if (wen_s && (csr_addr == 12'hB02)) begin
            ret_nxt_s = {ret64_s[63:32], wval_s};
        end else if (wen_s && (csr_addr == 12'hB82)) begin
            ret_nxt_s = {wval_s, ret64_s[31:0]};
        end else if (retire && !mcountinhibit_r[2]) begin
            ret_nxt_s = ret64_s + 64'd1;
        end else begin
            ret_nxt_s = ret64_s;
        end
    end

    // Counter registers; truncation to CNT_WIDTH gives the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle_r   <= '0;
            minstret_r <= '0;
        end else begin
            mcycle_r   <= cyc_nxt_s[CNT_WIDTH-1:0];
            minstret_r <= ret_nxt_s[CNT_WIDTH-1:0];
        end
    end

    // Interrupt source capture: core lines registered once, platform lines double-synchronised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_r     <= 1'b0;
            sw_r        <= 1'b0;
            ext_r       <= 1'b0;
            plat_meta_r <= '0;
            plat_sync_r <= '0;
        end else begin
            timer_r     <= timer_irq;
            sw_r        <= sw_irq;
            ext_r       <= ext_irq;
            plat_meta_r <= plat_irq;
            plat_sync_r <= plat_meta_r;
        end
    end

    // Priority encode: lowest platform line first, then 7, 3 and finally 11 override.
    always_comb begin
        code_s = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending_s[16 + i]) begin
                code_s = 5'(16 + i);
            end else begin
                code_s = code_s;
            end
        end
        if (pending_s[7]) begin
            code_s = 5'd7;
        end else begin
            code_s = code_s;
        end
        if (pending_s[3]) begin
            code_s = 5'd3;
        end else begin
            code_s = code_s;
        end
        if (pending_s[11]) begin
            code_s = 5'd11;
        end else begin
            code_s = code_s;
        end
    end

    assign irq_req   = mstatus_mie_r & (|pending_s);
    assign irq_cause = {1'b1, 26'd0, code_s};

    // Trap state: trap entry beats MRET, and both beat CSR writes to these registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_r  <= 1'b0;
            mstatus_mpie_r <= 1'b0;
            mepc_r         <= 32'd0;
            mcause_r       <= 32'd0;
            mtval_r        <= 32'd0;
        end else if (trap_valid) begin
            mstatus_mpie_r <= mstatus_mie_r;
            mstatus_mie_r  <= 1'b0;
            mepc_r         <= trap_pc & ADDR_MASK & ~32'd3;
            mcause_r       <= trap_cause;
            mtval_r        <= trap_value;
        end else if (mret) begin
            mstatus_mie_r  <= mstatus_mpie_r;
            mstatus_mpie_r <= 1'b1;
        end else if (wen_s) begin
            case (csr_addr)
                12'h300: begin
                    mstatus_mie_r  <= wval_s[3];
                    mstatus_mpie_r <= wval_s[7];
                end
                12'h341: mepc_r   <= wval_s;
                12'h342: mcause_r <= wval_s;
                12'h343: mtval_r  <= wval_s;
                default: mepc_r   <= mepc_r;
            endcase
        end
    end

    // Remaining writable CSRs commit regardless of trap/MRET activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_r           <= 32'd0;
            mtvec_r         <= 32'd0;
            mcountinhibit_r <= 32'd0;
            mscratch_r      <= 32'd0;
        end else if (wen_s) begin
            case (csr_addr)
                12'h304: mie_r           <= wval_s & MIE_MASK;
`ifdef CSR_VECTORED_EN
                12'h305: mtvec_r         <= {wval_s[31:2], 1'b0, wval_s[0]};
`else
                12'h305: mtvec_r         <= {wval_s[31:2], 2'b00};
`endif
                12'h320: mcountinhibit_r <= wval_s & 32'h0000_0005;
                12'h340: mscratch_r      <= wval_s;
                default: mscratch_r      <= mscratch_r;
            endcase
        end
    end

    assign tvec_base_s = mtvec_r & ADDR_MASK & ~32'd3;

`ifdef CSR_VECTORED_EN
    assign target_s = ((mtvec_r[1:0] == 2'b01) && trap_cause[31])
                    ? tvec_base_s + {25'd0, trap_cause[4:0], 2'b00}
                    : tvec_base_s;
`else
    assign target_s = tvec_base_s;
`endif

    assign trap_target = target_s;
    assign mepc_out    = mepc_r & ADDR_MASK;

endmodule

// File: tb/tb_rv32i_csr_irq.sv
// Scoreboard-driven bench for rv32i_csr_irq: expectations are queued as stimulus
// is applied and popped when the corresponding DUT output is sampled.
module tb_rv32i_csr_irq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] csr_addr = 12'h000;
    logic [2:0]  csr_op = 3'b000;
    logic [31:0] csr_wdata = 32'd0;
    logic        csr_we = 1'b0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        retire = 1'b0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_cause = 32'd0;
    logic [31:0] trap_pc = 32'd0;
    logic [31:0] trap_value = 32'd0;
    logic        mret = 1'b0;
    logic [63:0] mtime = 64'h1234_5678_9ABC_DEF0;
    logic        timer_irq = 1'b0;
    logic        sw_irq = 1'b0;
    logic        ext_irq = 1'b0;
    logic [3:0]  plat_irq = 4'b0000;
    logic        irq_req;
    logic [31:0] irq_cause;
    logic [31:0] trap_target;
    logic [31:0] mepc_out;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] ev;
    string       nm;

    rv32i_csr_irq dut (
        .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_wdata(csr_wdata), .csr_we(csr_we), .csr_rdata(csr_rdata),
        .csr_illegal(csr_illegal), .retire(retire), .trap_valid(trap_valid),
        .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_value(trap_value),
        .mret(mret), .mtime(mtime), .timer_irq(timer_irq), .sw_irq(sw_irq),
        .ext_irq(ext_irq), .plat_irq(plat_irq), .irq_req(irq_req),
        .irq_cause(irq_cause), .trap_target(trap_target), .mepc_out(mepc_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_push(input string n, input logic [31:0] v);
        name_q.push_back(n);
        exp_q.push_back(v);
    endtask

    task automatic csr_do(input logic [11:0] a, input logic [2:0] op, input logic [31:0] d);
        csr_addr  = a;
        csr_op    = op;
        csr_wdata = d;
        csr_we    = 1'b1;
        tick();
        csr_we    = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] addrs [3];
        addrs = '{12'h300, 12'h304, 12'hB00};
        tick();
        expect_push("irq_req_in_reset", 32'd0);
        expect_push("trap_target_in_reset", 32'd0);
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if ({31'd0, irq_req} !== ev) begin
            $display("FAIL %s: got %h want %h", nm, irq_req, ev); n_fails++;
        end
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (trap_target !== ev) begin
            $display("FAIL %s: got %h want %h", nm, trap_target, ev); n_fails++;
        end
        rst = 1'b0;
        repeat (5) tick();
        expect_push("mstatus_reset", 32'h0000_1800);
        expect_push("mie_reset", 32'd0);
        expect_push("mcycle_since_reset", 32'd5);
        for (int i = 0; i < 3; i++) begin
            csr_addr = addrs[i];
            #1;
            ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
            if (csr_rdata !== ev) begin
                $display("FAIL %s: got %h want %h", nm, csr_rdata, ev); n_fails++;
            end
        end
    endtask

    task automatic test_counters();
        csr_do(12'hB00, 3'b001, 32'hFFFF_FFFF);
        csr_do(12'hB80, 3'b001, 32'd0);
        tick();
        expect_push("mcycle_lo_carry", 32'd0);
        expect_push("mcycleh_carry", 32'd1);
        csr_addr = 12'hB00; #1;
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (csr_rdata !== ev) begin
            $display("FAIL %s: got %h want %h", nm, csr_rdata, ev); n_fails++;
        end
        csr_addr = 12'hB80; #1;
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (csr_rdata !== ev) begin
            $display("FAIL %s: got %h want %h", nm, csr_rdata, ev); n_fails++;
        end
        csr_do(12'hB02, 3'b001, 32'h0000_0010);
        retire = 1'b1;
        repeat (3) tick();
        retire = 1'b0;
        expect_push("minstret_count", 32'h0000_0013);
        expect_push("instret_shadow", 32'h0000_0013);
        csr_addr = 12'hB02; #1;
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (csr_rdata !== ev) begin
            $display("FAIL %s: got %h want %h", nm, csr_rdata, ev); n_fails++;
        end
        csr_addr = 12'hC02; #1;
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (csr_rdata !== ev) begin
            $display("FAIL %s: got %h want %h", nm, csr_rdata, ev); n_fails++;
        end
        // Inhibit both counters, then confirm they hold while retiring.
        csr_do(12'h320, 3'b110, 32'd5);
        csr_do(12'hB00, 3'b001, 32'h0000_0100);
        retire = 1'b1;
        repeat (2) tick();
        retire = 1'b0;
        expect_push("mcycle_inhibited", 32'h0000_0100);
        expect_push("minstret_inhibited", 32'h0000_0013);
        expect_push("mcountinhibit", 32'h0000_0005);
        csr_addr = 12'hB00; #1;
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (csr_rdata !== ev) begin
            $display("FAIL %s: got %h want %h", nm, csr_rdata, ev); n_fails++;
        end
        csr_addr = 12'hB02; #1;
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (csr_rdata !== ev) begin
            $display("FAIL %s: got %h want %h", nm, csr_rdata, ev); n_fails++;
        end
        csr_addr = 12'h320; #1;
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (csr_rdata !== ev) begin
            $display("FAIL %s: got %h want %h", nm, csr_rdata, ev); n_fails++;
        end
        csr_do(12'h320, 3'b111, 32'd5);
        tick();
        expect_push("mcycle_resumed", 32'h0000_0101);
        csr_addr = 12'hB00; #1;
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (csr_rdata !== ev) begin
            $display("FAIL %s: got %h want %h", nm, csr_rdata, ev); n_fails++;
        end
    endtask

    task automatic test_irq();
        int  lat;
        logic done;
        csr_do(12'h304, 3'b001, 32'h0001_0800);
        csr_do(12'h300, 3'b110, 32'd8);
        // Bounded wait for the synchronised platform line.
        expect_push("plat_latency", 32'd2);
        plat_irq = 4'b0001;
        lat = 99;
        done = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (!done) begin
                tick();
                if (irq_req) begin
                    lat  = c;
                    done = 1'b1;
                end
            end
        end
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (lat !== int'(ev)) begin
            $display("FAIL %s: got %0d want %0d", nm, lat, ev); n_fails++;
        end
        plat_irq = 4'b0000;
        repeat (2) tick();
        plat_irq = 4'b0001;
        ext_irq  = 1'b1;
        expect_push("irq_req_before_edge", 32'd0);
        expect_push("cause_ext_wins", 32'h8000_000B);
        expect_push("cause_plat0", 32'h8000_0010);
        expect_push("mip_plat0", 32'h0001_0000);
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if ({31'd0, irq_req} !== ev) begin
            $display("FAIL %s: got %h want %h", nm, irq_req, ev); n_fails++;
        end
        tick();
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (!irq_req || irq_cause !== ev) begin
            $display("FAIL %s: got req=%b cause=%h want %h", nm, irq_req, irq_cause, ev); n_fails++;
        end
        ext_irq = 1'b0;
        tick();
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (!irq_req || irq_cause !== ev) begin
            $display("FAIL %s: got req=%b cause=%h want %h", nm, irq_req, irq_cause, ev); n_fails++;
        end
        csr_addr = 12'h344; #1;
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (csr_rdata !== ev) begin
            $display("FAIL %s: got %h want %h", nm, csr_rdata, ev); n_fails++;
        end
        plat_irq = 4'b0000;
        csr_do(12'h304, 3'b001, 32'h0000_0888);
        sw_irq    = 1'b1;
        timer_irq = 1'b1;
        expect_push("cause_sw_over_timer", 32'h8000_0003);
        expect_push("cause_timer", 32'h8000_0007);
        expect_push("irq_req_mie_off", 32'd0);
        expect_push("mie_writable_mask", 32'h000F_0888);
        tick();
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (!irq_req || irq_cause !== ev) begin
            $display("FAIL %s: got req=%b cause=%h want %h", nm, irq_req, irq_cause, ev); n_fails++;
        end
        sw_irq = 1'b0;
        tick();
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (!irq_req || irq_cause !== ev) begin
            $display("FAIL %s: got req=%b cause=%h want %h", nm, irq_req, irq_cause, ev); n_fails++;
        end
        csr_do(12'h300, 3'b111, 32'd8);
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if ({31'd0, irq_req} !== ev) begin
            $display("FAIL %s: got %h want %h", nm, irq_req, ev); n_fails++;
        end
        timer_irq = 1'b0;
        csr_do(12'h304, 3'b001, 32'hFFFF_FFFF);
        csr_addr = 12'h304; #1;
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (csr_rdata !== ev) begin
            $display("FAIL %s: got %h want %h", nm, csr_rdata, ev); n_fails++;
        end
        csr_do(12'h304, 3'b001, 32'd0);
        csr_do(12'h300, 3'b110, 32'd8);
    endtask

    task automatic test_trap();
        logic [11:0] addrs [4];
        addrs = '{12'h300, 12'h341, 12'h342, 12'h343};
        csr_do(12'h305, 3'b001, 32'h0000_1001);
`ifdef CSR_VECTORED_EN
        expect_push("mtvec_read", 32'h0000_1001);
        expect_push("trap_target_irq", 32'h0000_1040);
`else
        expect_push("mtvec_read", 32'h0000_1000);
        expect_push("trap_target_irq", 32'h0000_1000);
`endif
        csr_addr = 12'h305; #1;
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (csr_rdata !== ev) begin
            $display("FAIL %s: got %h want %h", nm, csr_rdata, ev); n_fails++;
        end
        // Trap entry with a competing mepc write that must lose.
        trap_valid = 1'b1;
        trap_cause = 32'h8000_0010;
        trap_pc    = 32'hFF00_0087;
        trap_value = 32'h0000_0055;
        csr_addr   = 12'h341;
        csr_op     = 3'b001;
        csr_wdata  = 32'h0000_0200;
        csr_we     = 1'b1;
        #1;
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (trap_target !== ev) begin
            $display("FAIL %s: got %h want %h", nm, trap_target, ev); n_fails++;
        end
        tick();
        trap_valid = 1'b0;
        csr_we     = 1'b0;
        trap_cause = 32'h0000_0002;
        expect_push("mstatus_after_trap", 32'h0000_1880);
        expect_push("mepc_after_trap", 32'h0000_0084);
        expect_push("mcause_after_trap", 32'h8000_0010);
        expect_push("mtval_after_trap", 32'h0000_0055);
        for (int i = 0; i < 4; i++) begin
            csr_addr = addrs[i];
            #1;
            ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
            if (csr_rdata !== ev) begin
                $display("FAIL %s: got %h want %h", nm, csr_rdata, ev); n_fails++;
            end
        end
        expect_push("mepc_out", 32'h0000_0084);
        expect_push("trap_target_exc", 32'h0000_1000);
        expect_push("mstatus_after_mret", 32'h0000_1888);
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (mepc_out !== ev) begin
            $display("FAIL %s: got %h want %h", nm, mepc_out, ev); n_fails++;
        end
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (trap_target !== ev) begin
            $display("FAIL %s: got %h want %h", nm, trap_target, ev); n_fails++;
        end
        mret = 1'b1;
        tick();
        mret = 1'b0;
        csr_addr = 12'h300; #1;
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (csr_rdata !== ev) begin
            $display("FAIL %s: got %h want %h", nm, csr_rdata, ev); n_fails++;
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops  [6];
        logic [31:0] dats [6];
        logic [31:0] res  [6];
        ops  = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
        dats = '{32'h0000_F0F0, 32'h0000_0F00, 32'h0000_00F0,
                 32'hFFFF_FFF5, 32'h0000_000A, 32'h0000_0003};
        res  = '{32'h0000_F0F0, 32'h0000_FFF0, 32'h0000_FF00,
                 32'h0000_0015, 32'h0000_001F, 32'h0000_001C};
        // Trap and MRET together with a mscratch write: trap wins, mscratch still commits.
        trap_valid = 1'b1;
        mret       = 1'b1;
        trap_cause = 32'h0000_0002;
        csr_do(12'h340, 3'b001, 32'h0000_ABCD);
        trap_valid = 1'b0;
        expect_push("mstatus_trap_beats_mret", 32'h0000_1880);
        expect_push("mscratch_commit_with_trap", 32'h0000_ABCD);
        expect_push("mstatus_mret_beats_write", 32'h0000_1888);
        csr_addr = 12'h300; #1;
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (csr_rdata !== ev) begin
            $display("FAIL %s: got %h want %h", nm, csr_rdata, ev); n_fails++;
        end
        csr_addr = 12'h340; #1;
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (csr_rdata !== ev) begin
            $display("FAIL %s: got %h want %h", nm, csr_rdata, ev); n_fails++;
        end
        csr_do(12'h300, 3'b001, 32'd0);
        mret = 1'b0;
        csr_addr = 12'h300; #1;
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (csr_rdata !== ev) begin
            $display("FAIL %s: got %h want %h", nm, csr_rdata, ev); n_fails++;
        end
        // Consecutive mscratch ops: each cycle reads the previous op's result.
        expect_push("mscratch_old_0", 32'h0000_ABCD);
        for (int i = 0; i < 6; i++) begin
            csr_addr  = 12'h340;
            csr_op    = ops[i];
            csr_wdata = dats[i];
            csr_we    = 1'b1;
            #1;
            ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
            if (csr_rdata !== ev) begin
                $display("FAIL %s step %0d: got %h want %h", nm, i, csr_rdata, ev); n_fails++;
            end
            expect_push("mscratch_seq", res[i]);
            tick();
        end
        csr_we = 1'b0;
        #1;
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (csr_rdata !== ev) begin
            $display("FAIL %s final: got %h want %h", nm, csr_rdata, ev); n_fails++;
        end
    endtask

    task automatic test_illegal();
        csr_addr  = 12'hC00;
        csr_op    = 3'b001;
        csr_wdata = 32'h0000_0999;
        csr_we    = 1'b1;
        #1;
        expect_push("illegal_write_cycle", 32'd1);
        expect_push("illegal_write_instret", 32'd1);
        expect_push("minstret_unchanged", 32'h0000_0013);
        expect_push("illegal_unimpl", 32'd1);
        expect_push("f11_reads_zero", 32'd0);
        expect_push("f11_legal", 32'd0);
        expect_push("misa", 32'h4000_0100);
        expect_push("timeh", 32'h1234_5678);
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if ({31'd0, csr_illegal} !== ev) begin
            $display("FAIL %s: got %h want %h", nm, csr_illegal, ev); n_fails++;
        end
        tick();
        csr_addr = 12'hC02;
        csr_we   = 1'b1;
        #1;
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if ({31'd0, csr_illegal} !== ev) begin
            $display("FAIL %s: got %h want %h", nm, csr_illegal, ev); n_fails++;
        end
        tick();
        csr_we   = 1'b0;
        csr_addr = 12'hB02; #1;
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (csr_rdata !== ev) begin
            $display("FAIL %s: got %h want %h", nm, csr_rdata, ev); n_fails++;
        end
        csr_addr = 12'h7C0; #1;
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if ({31'd0, csr_illegal} !== ev) begin
            $display("FAIL %s: got %h want %h", nm, csr_illegal, ev); n_fails++;
        end
        csr_addr = 12'hF11; #1;
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (csr_rdata !== ev) begin
            $display("FAIL %s: got %h want %h", nm, csr_rdata, ev); n_fails++;
        end
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if ({31'd0, csr_illegal} !== ev) begin
            $display("FAIL %s: got %h want %h", nm, csr_illegal, ev); n_fails++;
        end
        csr_addr = 12'h301; #1;
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (csr_rdata !== ev) begin
            $display("FAIL %s: got %h want %h", nm, csr_rdata, ev); n_fails++;
        end
        csr_addr = 12'hC81; #1;
        ev = exp_q.pop_front(); nm = name_q.pop_front(); n_checks++;
        if (csr_rdata !== ev) begin
            $display("FAIL %s: got %h want %h", nm, csr_rdata, ev); n_fails++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_counters();
        test_irq();
        test_trap();
        test_back_to_back();
        test_illegal();
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
            n_fails++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
